// File: rtl/keypad_pkg.sv
// keypad_pkg: scan FSM encoding, key-index width and {press, key} event layout.
// The press bit is only part of an event when KEYPAD_RELEASE_EVENT_EN is defined.
package keypad_pkg;

    typedef enum logic [1:0] {SETTLE, UPDATE, ADVANCE} scan_state_e;

`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam int PRESS_W = 1;
`else
    localparam int PRESS_W = 0;
`endif

    function automatic int key_w(input int n_keys);
        return $clog2(n_keys);
    endfunction

    function automatic int ev_w(input int n_keys);
        return key_w(n_keys) + PRESS_W;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: first-word-fall-through queue; when full, a same-cycle pop
// frees the slot first so the push still lands.
module keypad_event_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0] cnt_q;
    logic do_pop, do_push;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: prescaled column scan, per-key debounce and a queued event stream.
// Define KEYPAD_RELEASE_EVENT_EN to also queue release events (EV_PRESS = 0).
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS         = 4,
    parameter int N_COLS         = 4,
    parameter int TICK_DIV       = 8192,
    parameter int SETTLE_TICKS   = 1,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int EV_DEPTH       = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    output logic [N_COLS-1:0]               COL_DRIVE,
    input  logic [N_ROWS-1:0]               ROW_SENSE,
    output logic [N_ROWS*N_COLS-1:0]        KEYS,
    output logic                            EV_VALID,
    input  logic                            EV_READY,
    output logic [key_w(N_ROWS*N_COLS)-1:0] EV_KEY,
    output logic                            EV_PRESS,
    output logic                            OVERFLOW
);
    localparam int N_KEYS = N_ROWS * N_COLS;
    localparam int KW     = key_w(N_KEYS);
    localparam int EW     = ev_w(N_KEYS);
    localparam int TW     = $clog2(TICK_DIV);
    localparam int DW     = $clog2(SETTLE_TICKS + 1);
    localparam int RW     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW     = $clog2(N_COLS);

    scan_state_e state_q, state_d;
    logic [N_ROWS-1:0] sync1_q, sync2_q, samp_q, samp_d;
    logic [TW-1:0] tick_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [N_KEYS-1:0] keys_q, keys_d;
    logic [3:0] cnt_q [N_KEYS];
    logic [3:0] cnt_d [N_KEYS];
    logic ev_vld_q, ev_vld_d, ovf_q, ovf_d;
    logic [EW-1:0] ev_dat_q, ev_dat_d, head;
    logic [KW-1:0] k;
    logic tick, pop, empty, full;

    assign tick = tick_q == TW'(TICK_DIV - 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            tick_q   <= '0;
            state_q  <= SETTLE;
            dwell_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            samp_q   <= '0;
            keys_q   <= '0;
            cnt_q    <= '{default: '0};
            ev_vld_q <= 1'b0;
            ev_dat_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= ROW_SENSE;
            sync2_q  <= sync1_q;
            tick_q   <= tick ? '0 : tick_q + 1'b1;
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            row_q    <= row_d;
            col_q    <= col_d;
            samp_q   <= samp_d;
            keys_q   <= keys_d;
            cnt_q    <= cnt_d;
            ev_vld_q <= ev_vld_d;
            ev_dat_q <= ev_dat_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        row_d    = row_q;
        col_d    = col_q;
        samp_d   = samp_q;
        keys_d   = keys_q;
        cnt_d    = cnt_q;
        ev_vld_d = 1'b0;
        ev_dat_d = ev_dat_q;
        ovf_d    = ovf_q | (ev_vld_q & full & ~pop);
        k        = KW'(int'(row_q) * N_COLS + int'(col_q));
        case (state_q)
            SETTLE: begin
                if (tick) begin
                    if (dwell_q == DW'(SETTLE_TICKS - 1)) begin
                        samp_d  = ~sync2_q;
                        dwell_d = '0;
                        row_d   = '0;
                        state_d = UPDATE;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            UPDATE: begin
                if (samp_q[row_q] == keys_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == 4'(DEBOUNCE_SCANS - 1)) begin
                    cnt_d[k]  = '0;
                    keys_d[k] = ~keys_q[k];
`ifdef KEYPAD_RELEASE_EVENT_EN
                    ev_vld_d  = 1'b1;
                    ev_dat_d  = {~keys_q[k], k};
`else
                    ev_vld_d  = ~keys_q[k];
                    ev_dat_d  = k;
`endif
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
                row_d = row_q + 1'b1;
                if (row_q == RW'(N_ROWS - 1))
                    state_d = ADVANCE;
            end
            default: begin
                col_d   = (col_q == CW'(N_COLS - 1)) ? '0 : col_q + 1'b1;
                state_d = SETTLE;
            end
        endcase
    end

    // Events go through one register stage, so they surface the cycle after KEYS changes.
    keypad_event_fifo #(.W(EW), .DEPTH(EV_DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (ev_vld_q),
        .data_i  (ev_dat_q),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

    assign pop       = EV_READY & ~empty;
    assign EV_VALID  = ~empty;
    assign EV_KEY    = head[KW-1:0];
    assign KEYS      = keys_q;
    assign OVERFLOW  = ovf_q;
    assign COL_DRIVE = ~(N_COLS'(1) << col_q);
`ifdef KEYPAD_RELEASE_EVENT_EN
    assign EV_PRESS  = head[EW-1];
`else
    assign EV_PRESS  = 1'b1;
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: emulated key matrix driving the scanner, checked every cycle
// against a schedule-level debounce/queue model plus hand-computed anchor points.
module tb_keypad_matrix_scanner;
    localparam int NR = 4, NC = 4, TD = 8, ST = 2, DB = 3, DEPTH = 4;
    localparam int NK = NR * NC, KW = $clog2(NK), SCAN = ST * TD;
`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic CLK = 1'b0, RST = 1'b1, EV_READY = 1'b0;
    logic [NC-1:0] COL_DRIVE;
    logic [NR-1:0] ROW_SENSE;
    logic [NK-1:0] KEYS;
    logic EV_VALID, EV_PRESS, OVERFLOW;
    logic [KW-1:0] EV_KEY;
    logic [NK-1:0] pressed = '0;

    int n, vectors, miscompares;
    logic [NK-1:0] m_keys, m_samp, h1, h2;
    int m_cnt [NK];
    int m_col, m_t;
    logic m_pend, m_ovf;
    logic [KW:0] m_pev;
    logic [KW:0] m_q [$];
    logic [KW:0] got [$];

    keypad_matrix_scanner #(
        .N_ROWS(NR), .N_COLS(NC), .TICK_DIV(TD), .SETTLE_TICKS(ST),
        .DEBOUNCE_SCANS(DB), .EV_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST), .COL_DRIVE(COL_DRIVE), .ROW_SENSE(ROW_SENSE),
        .KEYS(KEYS), .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_KEY(EV_KEY),
        .EV_PRESS(EV_PRESS), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        ROW_SENSE = '1;
        for (int r = 0; r < NR; r++)
            ROW_SENSE[r] = ~|(pressed[r*NC +: NC] & ~COL_DRIVE);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, n, act, exp);
        end
    endtask

    task automatic eval_key(input int r);
        int k;
        k = r * NC + m_col;
        if (m_samp[k] == m_keys[k]) begin
            m_cnt[k] = 0;
        end else begin
            m_cnt[k]++;
            if (m_cnt[k] == DB) begin
                m_cnt[k] = 0;
                m_keys[k] = ~m_keys[k];
                if (m_keys[k] || REL) begin
                    m_pend = 1'b1;
                    m_pev = {m_keys[k], KW'(k)};
                end
            end
        end
    endtask

    // Called at the negedge of cycle n with that cycle's stimulus already applied.
    task automatic step();
        logic [NC-1:0] ecol;
        logic [KW:0] hd;
        ecol = '1;
        ecol[m_col] = 1'b0;
        chk("col_drive", 32'(COL_DRIVE), 32'(ecol));
        chk("keys", 32'(KEYS), 32'(m_keys));
        chk("ev_valid", 32'(EV_VALID), 32'(m_q.size() != 0));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
        if (m_q.size() != 0) begin
            hd = m_q[0];
            chk("ev_key", 32'(EV_KEY), 32'(hd[KW-1:0]));
            chk("ev_press", 32'(EV_PRESS), 32'(hd[KW]));
        end
        if (EV_VALID && EV_READY)
            got.push_back({EV_PRESS, EV_KEY});
        if (m_q.size() != 0 && EV_READY)
            void'(m_q.pop_front());
        if (m_pend) begin
            if (m_q.size() < DEPTH)
                m_q.push_back(m_pev);
            else
                m_ovf = 1'b1;
            m_pend = 1'b0;
        end
        if ((n + 1) % SCAN == 0) begin
            m_t = n;
            m_samp = h2;
        end
        if (m_t >= 0 && n > m_t && n <= m_t + NR)
            eval_key(n - m_t - 1);
        if (m_t >= 0 && n == m_t + NR + 1)
            m_col = (m_col + 1) % NC;
        h2 = h1;
        h1 = pressed;
        n++;
        @(negedge CLK);
    endtask

    task automatic run_until(input int m);
        while (n < m)
            step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        n = 0;
        m_keys = '0;
        m_cnt = '{default: 0};
        m_col = 0;
        m_t = -1;
        m_pend = 1'b0;
        m_ovf = 1'b0;
        m_q.delete();
        got.delete();
        h1 = pressed;
        h2 = pressed;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        EV_READY = 1'b1;
        @(negedge CLK);

        // Idle scan: column rotation and reset values
        do_reset();
        chk("rst_col", 32'(COL_DRIVE), 32'h0000_000e);
        chk("rst_keys", 32'(KEYS), 32'h0);
        chk("rst_valid", 32'(EV_VALID), 32'h0);
        chk("rst_ovf", 32'(OVERFLOW), 32'h0);
        run_until(20);
        chk("col0_last", 32'(COL_DRIVE), 32'h0000_000e);
        step();
        chk("col1", 32'(COL_DRIVE), 32'h0000_000d);
        run_until(37);
        chk("col2", 32'(COL_DRIVE), 32'h0000_000b);
        run_until(53);
        chk("col3", 32'(COL_DRIVE), 32'h0000_0007);
        run_until(69);
        chk("col_wrap", 32'(COL_DRIVE), 32'h0000_000e);
        run_until(140);

        // Key 6 held: third column-2 sample at cycle 175, row 1
        pressed = '0;
        pressed[6] = 1'b1;
        do_reset();
        run_until(177);
        chk("k6_before", 32'(KEYS), 32'h0);
        step();
        chk("k6_keys", 32'(KEYS), 32'h0040);
        chk("k6_not_yet", 32'(EV_VALID), 32'h0);
        step();
        chk("k6_valid", 32'(EV_VALID), 32'h1);
        chk("k6_key", 32'(EV_KEY), 32'd6);
        chk("k6_press", 32'(EV_PRESS), 32'h1);
        step();
        chk("k6_one_cycle", 32'(EV_VALID), 32'h0);
        run_until(300);
        chk("k6_count", 32'(got.size()), 32'd1);

        // Bounce: 2 pressed samples, 1 released, 2 pressed
        pressed = '0;
        pressed[6] = 1'b1;
        do_reset();
        run_until(140);
        pressed[6] = 1'b0;
        run_until(200);
        pressed[6] = 1'b1;
        run_until(330);
        pressed[6] = 1'b0;
        run_until(400);
        chk("bounce_keys", 32'(KEYS), 32'h0);
        chk("bounce_events", 32'(got.size()), 32'd0);

        // Overflow: keys 0..4 pressed in turn, consumer stalled
        EV_READY = 1'b0;
        pressed = '0;
        pressed[0] = 1'b1;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            run_until(80 * i);
            pressed[i] = 1'b1;
        end
        run_until(520);
        chk("ovf_valid", 32'(EV_VALID), 32'h1);
        chk("ovf_head", 32'(EV_KEY), 32'd0);
        chk("ovf_flag", 32'(OVERFLOW), 32'h1);
        EV_READY = 1'b1;
        run_until(560);
        chk("ovf_drained", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (got.size() > i)
                chk("ovf_order", 32'(got[i]), 32'({1'b1, KW'(i)}));
        chk("ovf_sticky", 32'(OVERFLOW), 32'h1);
        do_reset();
        chk("ovf_cleared", 32'(OVERFLOW), 32'h0);

        // Press then release key 15
        pressed = '0;
        pressed[15] = 1'b1;
        do_reset();
        run_until(260);
        pressed[15] = 1'b0;
        run_until(520);
        chk("k15_count", 32'(got.size()), REL ? 32'd2 : 32'd1);
        if (got.size() > 0) begin
            chk("k15_first", 32'(got[0]), 32'({1'b1, KW'(15)}));
            chk("k15_last", 32'(got[got.size()-1]), REL ? 32'({1'b0, KW'(15)}) : 32'({1'b1, KW'(15)}));
        end

        // Reset during UPDATE with two events queued
        EV_READY = 1'b0;
        pressed = '0;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        do_reset();
        run_until(176);
        chk("mid_queued", 32'(m_q.size()), 32'd2);
        chk("mid_valid", 32'(EV_VALID), 32'h1);
        chk("mid_head", 32'(EV_KEY), 32'd0);
        do_reset();
        chk("mid_rst_col", 32'(COL_DRIVE), 32'h0000_000e);
        chk("mid_rst_keys", 32'(KEYS), 32'h0);
        chk("mid_rst_valid", 32'(EV_VALID), 32'h0);
        chk("mid_rst_ovf", 32'(OVERFLOW), 32'h0);
        EV_READY = 1'b1;
        run_until(300);

        // Random key activity with a mostly stalled, then mostly ready consumer
        pressed = '0;
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if (i == 4000)
                do_reset();
            if ($urandom_range(0, 99) == 0)
                begin
                    int j;
                    j = $urandom_range(0, NK - 1);
                    pressed[j] = ~pressed[j];
                end
            EV_READY = $urandom_range(0, 7) < ((i < 3000) ? 1 : 6);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Parametrised row/column key-matrix scanner that generalises the board's fixed 4x4 button scan to N_ROWS x N_COLS.
- Adds a prescaler, per-key debouncing, a stable key-state vector and a queued press-event stream with a valid/ready handshake.
- Sits between the board matrix pins and the CPU/testbench core; replaces the free-running shift-register scan in the board top level.

Parameters:
- N_ROWS, 4, sensed rows (ROW_SENSE width), 1..8
- N_COLS, 4, driven columns (COL_DRIVE width), 2..8
- TICK_DIV, 8192, CLK cycles per scan tick; must be >= N_ROWS+4
- SETTLE_TICKS, 1, ticks each column is driven before sampling, >= 1
- DEBOUNCE_SCANS, 3, consecutive disagreeing samples needed to flip a key, 1..15
- EV_DEPTH, 4, event FIFO depth, power of two >= 2

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- COL_DRIVE  out  N_COLS  active-low one-hot column drive
- ROW_SENSE  in  N_ROWS  active-low row sense, asynchronous to CLK
- KEYS  out  N_ROWS*N_COLS  debounced key state; bit k = row*N_COLS+col; 1 = pressed
- EV_VALID  out  1  event available at FIFO head
- EV_READY  in  1  consumer accepts head event when EV_VALID & EV_READY
- EV_KEY  out  clog2(N_ROWS*N_COLS)  key index of head event
- EV_PRESS  out  1  1 = press, 0 = release (constant 1 without macro)
- OVERFLOW  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Reset values: COL_DRIVE = all ones except bit0 = 0; KEYS = 0; all debounce counters = 0; FIFO empty; EV_VALID = 0; OVERFLOW = 0; tick counter = 0; FSM = SETTLE, dwell count = 0.
- RST mid-scan or mid-handshake aborts immediately; queued events are discarded.
- ROW_SENSE passes through a 2-flop synchroniser before use, inverted so that 1 = pressed.
- Prescaler: counts 0..TICK_DIV-1 and wraps. Tick pulse is asserted for one cycle at TICK_DIV-1.
- SETTLE state: increment the dwell count on each tick. On the tick that makes dwell = SETTLE_TICKS, capture the synchronised rows into a sample register, clear dwell and enter UPDATE with row = 0.
- UPDATE state: processes one row per cycle for N_ROWS cycles on key k = row*N_COLS+col.
  - sample == KEYS[k]: counter[k] <= 0.
  - Otherwise counter[k]++. When the count reaches DEBOUNCE_SCANS, KEYS[k] toggles the next cycle, counter[k] <= 0 and an event is generated.
  - After the last row, enter ADVANCE.
- ADVANCE state: lasts one cycle. Rotate COL_DRIVE to the next column (col N_COLS-1 wraps to 0), then return to SETTLE.
- Scan period = N_COLS * SETTLE_TICKS * TICK_DIV cycles, unaffected by UPDATE or ADVANCE.
- Event generation: a press event is generated for 0->1 transitions. Release events (1->0) are generated only with the macro.
- FIFO full when an event is generated: the event is dropped, OVERFLOW <= 1, and KEYS still updates.
- FIFO push and pop in the same cycle when full: the pop frees the slot first, so the push succeeds.
- The FIFO is first-word fall-through: EV_KEY and EV_PRESS are stable while EV_VALID & !EV_READY.
- Minimum latency: the event appears on EV_VALID the cycle after the KEYS change.
- OVERFLOW clears only on RST.

Optional Feature:
- Macro: KEYPAD_RELEASE_EVENT_EN.
- Defined: 1->0 transitions also push events with EV_PRESS = 0.
- Undefined: only presses are queued, EV_PRESS is tied to 1, and the FIFO entry omits the press bit.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state encoding (SETTLE, UPDATE, ADVANCE)
  - the key-index width function (clog2 of N_ROWS*N_COLS)
  - the event field layout: {press, key}
- Sub-module keypad_event_fifo: parametrised-width/depth first-word-fall-through FIFO with full/empty flags and the simultaneous push/pop rule above.
- The prescaler, synchroniser, scan FSM and debounce counters stay in the top block.

Test Plan:
(All use N_ROWS=4, N_COLS=4, TICK_DIV=8, SETTLE_TICKS=2, DEBOUNCE_SCANS=3, giving a 64-cycle scan.)
- Reset then idle, all rows high: COL_DRIVE cycles 1110,1101,1011,0111 with 16-cycle dwell each; KEYS = 0; EV_VALID = 0 throughout.
- Hold key 6 (row 1, col 2) low for 4 scans, EV_READY = 1: KEYS[6] = 1 after the third scan of column 2; exactly one event EV_KEY = 6, EV_PRESS = 1; EV_VALID high for one cycle.
- Bounce: key 6 low for 2 scans, high for 1, low for 2: KEYS[6] stays 0 and no event is generated.
- EV_READY = 0; press keys 0, 1, 2, 3, 4 in turn: events 0 to 3 are held in order and EV_KEY is stable at 0; key 4 is dropped and OVERFLOW = 1; after draining, 4 events are seen and OVERFLOW stays 1 until RST.
- With KEYPAD_RELEASE_EVENT_EN, press then release key 15: event {1,15} then {0,15}; without the macro, only {1,15} appears.
- Assert RST for 1 cycle during UPDATE with 2 events queued: next cycle all outputs equal their reset values and the FIFO is empty.
